// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_access_unit                                               |
// | Purpose  : Load/store sequencer in front of a word-addressed data memory |
// |            (negedge access). Converts byte-addressed LB/LBU/LH/LHU/LW/   |
// |            SB/SH/SW requests into word reads/writes. Sub-word stores use |
// |            read-modify-write. Loads get lane extraction and sign or zero |
// |            extension. Misaligned, illegal-size and out-of-range requests |
// |            are rejected without touching memory.                         |
// | Ports    : CLK, Reset          clock / synchronous active-high reset     |
// |            req, we, size, sign_ext, addr, wdata   CPU request           |
// |            ready, done, err, rdata                CPU response          |
// |            mem_rw, mem_addr, mem_wdata, mem_rdata memory side           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mem_access_unit #(
    parameter int MEM_WORDS = 311
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0]  c_SZ_BYTE   = 2'b00;
    localparam logic [1:0]  c_SZ_HALF   = 2'b01;
    localparam logic [1:0]  c_SZ_WORD   = 2'b10;
    localparam logic [1:0]  c_SZ_BAD    = 2'b11;
    // One bit wider than the word index so the range compare cannot wrap.
    localparam logic [30:0] c_MEM_WORDS = 31'(MEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_sign_ext;
    logic [1:0]  r_off;
    logic [15:0] r_wdata_lo;   // only the low half is needed for sub-word merges

    logic        w_reject;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    // Request screening, evaluated on the live inputs at the accept edge.
    always_comb begin
        w_reject = 1'b0;
        case (size)
            c_SZ_HALF: w_reject = addr[0];
            c_SZ_WORD: w_reject = (addr[1:0] != 2'b00);
            c_SZ_BAD:  w_reject = 1'b1;
            default:   w_reject = 1'b0;
        endcase
        if ({1'b0, addr[31:2]} >= c_MEM_WORDS) begin
            w_reject = 1'b1;
        end
    end

    // Lane extraction for loads and lane replacement for sub-word stores,
    // both working on the word arriving from memory at the end of READ.
    always_comb begin
        case (r_off)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (r_size)
            c_SZ_BYTE: w_load = {{24{r_sign_ext & w_byte[7]}}, w_byte};
            c_SZ_HALF: w_load = {{16{r_sign_ext & w_half[15]}}, w_half};
            default:   w_load = mem_rdata;
        endcase

        w_merge = mem_rdata;
        if (r_size == c_SZ_BYTE) begin
            case (r_off)
                2'd0:    w_merge[7:0]   = r_wdata_lo[7:0];
                2'd1:    w_merge[15:8]  = r_wdata_lo[7:0];
                2'd2:    w_merge[23:16] = r_wdata_lo[7:0];
                default: w_merge[31:24] = r_wdata_lo[7:0];
            endcase
        end else if (r_off[1]) begin
            w_merge[31:16] = r_wdata_lo;
        end else begin
            w_merge[15:0]  = r_wdata_lo;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_sign_ext <= 1'b0;
            r_off      <= 2'b00;
            r_wdata_lo <= 16'h0000;
            ready      <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            rdata      <= 32'h0000_0000;
            mem_rw     <= 1'b0;
            mem_addr   <= 32'h0000_0000;
            mem_wdata  <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_we       <= we;
                        r_size     <= size;
                        r_sign_ext <= sign_ext;
                        r_off      <= addr[1:0];
                        r_wdata_lo <= wdata[15:0];
                        ready      <= 1'b0;
                        if (w_reject) begin
                            // Rejected: skip memory entirely, rdata is left alone.
                            done    <= 1'b1;
                            err     <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            mem_addr <= {2'b00, addr[31:2]};
                            if (we && (size == c_SZ_WORD)) begin
                                mem_wdata <= wdata;
                                mem_rw    <= 1'b1;
                                r_state   <= S_WRITE;
                            end else begin
                                r_state <= S_READ;
                            end
                        end
                    end
                end

                S_READ: begin
                    if (r_we) begin
                        // Write enable only rises here, so a reset during READ
                        // never lets the merged word reach memory.
                        mem_wdata <= w_merge;
                        mem_rw    <= 1'b1;
                        r_state   <= S_WRITE;
                    end else begin
                        rdata   <= w_load;
                        done    <= 1'b1;
                        err     <= 1'b0;
                        r_state <= S_RESP;
                    end
                end

                S_WRITE: begin
                    mem_rw  <= 1'b0;
                    done    <= 1'b1;
                    err     <= 1'b0;
                    r_state <= S_RESP;
                end

                S_RESP: begin
                    done    <= 1'b0;
                    err     <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    mem_rw  <= 1'b0;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_access_unit                                            |
// | Purpose  : Self-checking bench for mem_access_unit with a word memory    |
// |            model and a byte-level reference model of the access rules.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mem_access_unit;

    localparam int c_MEM_WORDS = 311;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        ready, done, err, mem_rw;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    mem_access_unit #(.MEM_WORDS(c_MEM_WORDS)) dut (
        .CLK(CLK), .Reset(Reset), .req(req), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .ready(ready),
        .done(done), .err(err), .rdata(rdata), .mem_rw(mem_rw),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    // Data memory: negedge access, write when RW=1, otherwise drive DataOut.
    logic [31:0] tmem [c_MEM_WORDS];
    always @(negedge CLK) begin
        if (mem_rw) begin
            if (mem_addr < c_MEM_WORDS) tmem[mem_addr[8:0]] = mem_wdata;
        end else begin
            mem_rdata = (mem_addr < c_MEM_WORDS) ? tmem[mem_addr[8:0]] : 32'h0;
        end
    end

    // Reference model state and expectations
    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          lat;
        int          wr;
        logic [31:0] idx;
        logic [31:0] wword;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [c_MEM_WORDS];
    logic [31:0] model_rdata = 32'h0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          wr_seen = 0;
    bit          manual = 1'b0;
    bit          last_err = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic exp_t predict(bit w, logic [1:0] sz, bit sx,
                                     logic [31:0] a, logic [31:0] d);
        exp_t        e;
        int          nbytes;
        int          sh;
        logic [31:0] mask, word, v;
        e.err = 1'b0; e.rdata = model_rdata; e.wr = 0; e.idx = a >> 2;
        e.wword = 32'h0; e.lat = 1; e.acc = 0;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (sz == 2'd3 || (a % nbytes) != 0 || (a >> 2) >= c_MEM_WORDS) begin
            e.err = 1'b1;
            return e;
        end
        sh   = 8 * int'(a % 4);
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
        word = ref_mem[e.idx[8:0]];
        if (!w) begin
            v = (word >> sh) & mask;
            if (sx && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
            e.rdata = v;
            e.lat   = 2;
        end else begin
            e.wword = (word & ~(mask << sh)) | ((d & mask) << sh);
            e.wr    = 1;
            e.lat   = (nbytes == 4) ? 2 : 3;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Present a request; it is accepted on the first edge where ready=1.
    task automatic issue(input bit w, input logic [1:0] sz, input bit sx,
                         input logic [31:0] a, input logic [31:0] d, input bit hold);
        exp_t e;
        int   t;
        t = 0;
        @(negedge CLK);
        while (!ready && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (!ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: ready stuck at %b expected 1", ready);
            return;
        end
        we = w; size = sz; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
        @(posedge CLK);
        #1;
        if (!hold) req = 1'b0;
        e     = predict(w, sz, sx, a, d);
        e.acc = cyc;
        if (!e.err) begin
            if (w) ref_mem[e.idx[8:0]] = e.wword;
            else   model_rdata = e.rdata;
        end
        q.push_back(e);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: %0d outstanding expected 0", q.size());
            q.delete();
        end
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", {31'h0, ready}, 32'h1);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_rw", {31'h0, mem_rw}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
    endtask

    // Per-cycle comparison against the model
    always @(negedge CLK) begin
        int lat;
        if (!Reset) begin
            if (!manual) begin
                n_cmp++;
                if (ready !== (q.size() == 0)) begin
                    n_bad++;
                    $display("FAIL ready: got %b expected %b", ready, q.size() == 0);
                end
            end
            if (mem_rw) begin
                n_cmp++;
                wr_seen++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL spurious_write: mem_rw=1 addr %h expected no write", mem_addr);
                end else if (q[0].wr == 0 || mem_addr !== q[0].idx || mem_wdata !== q[0].wword) begin
                    n_bad++;
                    $display("FAIL write: got addr %h data %h expected addr %h data %h (wr=%0d)",
                             mem_addr, mem_wdata, q[0].idx, q[0].wword, q[0].wr);
                end
            end
            if (done) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_done: done=1 expected 0");
                end else begin
                    lat = cyc - q[0].acc + 1;
                    last_err = err;
                    if (err !== q[0].err || rdata !== q[0].rdata || lat != q[0].lat || wr_seen != q[0].wr) begin
                        n_bad++;
                        $display("FAIL response: got err %b rdata %h lat %0d writes %0d expected err %b rdata %h lat %0d writes %0d",
                                 err, rdata, lat, wr_seen, q[0].err, q[0].rdata, q[0].lat, q[0].wr);
                    end
                    void'(q.pop_front());
                end
                wr_seen = 0;
            end
        end
    end

    initial begin
        for (int i = 0; i < c_MEM_WORDS; i++) begin
            tmem[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_reset_vals();
        @(posedge CLK);
        #1 Reset = 1'b0;

        // Reset held two cycles while an SB sits in READ
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, 1'b0);
        wait_idle();
        @(negedge CLK);
        manual = 1'b1;
        we = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 32'h21; wdata = 32'h0000_00AA; req = 1'b1;
        @(posedge CLK);
        #1 req = 1'b0; Reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0; manual = 1'b0; model_rdata = 32'h0;
        @(negedge CLK);
        chk_reset_vals();
        @(negedge CLK);
        chk("rst_ready_after", {31'h0, ready}, 32'h1);
        chk("rst_word_kept", tmem[8], 32'h1122_3344);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0);
        wait_idle();
        chk("rst_lw_after", rdata, 32'h1122_3344);

        // SW then LW
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
        wait_idle();
        chk("sw_mem4", tmem[4], 32'hDEAD_BEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
        wait_idle();
        chk("lw_rdata", rdata, 32'hDEAD_BEEF);
        chk("lw_err", {31'h0, last_err}, 32'h0);

        // SB read-modify-write
        issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_007F, 1'b0);
        wait_idle();
        chk("sb_mem4", tmem[4], 32'hDEAD_7FEF);

        // Sub-word loads
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0);
        wait_idle();
        chk("lb_13", rdata, 32'hFFFF_FFDE);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0);
        wait_idle();
        chk("lbu_13", rdata, 32'h0000_00DE);
        issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0);
        wait_idle();
        chk("lhu_12", rdata, 32'h0000_DEAD);
        issue(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 1'b0);
        wait_idle();
        chk("lh_10", rdata, 32'h0000_7FEF);

        // Rejected accesses leave rdata and memory alone
        issue(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 1'b0);
        wait_idle();
        chk("err_lw_mis", {31'h0, last_err}, 32'h1);
        issue(1'b1, 2'd1, 1'b0, 32'h11, 32'hFFFF_FFFF, 1'b0);
        wait_idle();
        chk("err_sh_mis", {31'h0, last_err}, 32'h1);
        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b0);
        wait_idle();
        chk("err_size3", {31'h0, last_err}, 32'h1);
        issue(1'b0, 2'd2, 1'b0, 32'(4 * c_MEM_WORDS), 32'h0, 1'b0);
        wait_idle();
        chk("err_range", {31'h0, last_err}, 32'h1);
        chk("err_rdata_held", rdata, 32'h0000_7FEF);
        chk("err_mem4_kept", tmem[4], 32'hDEAD_7FEF);

        // Last valid word, and an upper-half SH
        issue(1'b1, 2'd2, 1'b0, 32'(4 * (c_MEM_WORDS - 1)), 32'hCAFE_F00D, 1'b0);
        issue(1'b1, 2'd1, 1'b0, 32'(4 * (c_MEM_WORDS - 1) + 2), 32'h0000_1234, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'(4 * (c_MEM_WORDS - 1)), 32'h0, 1'b0);
        wait_idle();
        chk("last_word", rdata, 32'h1234_F00D);

        // req held high: alternating SW/LW
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 2'd2, 1'b0, 32'h40 + 32'(4 * (i % 4)), $urandom, 1'b1);
            issue(1'b0, 2'd2, 1'b0, 32'h40 + 32'(4 * ((i + 1) % 4)), 32'h0, 1'b1);
        end
        req = 1'b0;
        wait_idle();
        repeat (3) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
